// File: rtl/prime_scan_ctrl.sv
// Sweep sequencer for the 3-bit prime detector: drives codes 0..7, samples P
// after a settle dwell, and publishes a registered prime map, count and mismatch flag.
module prime_scan_ctrl #(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    output logic               c,
    output logic               b,
    output logic               a,
    input  logic               p_in,
    output logic               busy,
    output logic               done,
    output logic [7:0]         prime_map,
    output logic [3:0]         prime_count,
    output logic               mismatch,
    output logic [SWEEP_W-1:0] sweep_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] PRIME_REF  = 8'hAC;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    state_e               state_q, state_d;
    logic [2:0]           code_q, code_d;
    logic [7:0]           dwell_q, dwell_d;
    logic                 mode_q, mode_d;
    logic [7:0]           shadow_q, shadow_d;
    logic [7:0]           map_q, map_d;
    logic [3:0]           count_q, count_d;
    logic                 mismatch_q, mismatch_d;
    logic [SWEEP_W-1:0]   sweep_q, sweep_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state logic: stop overrides everything; results only move on entry to DONE.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        dwell_d    = dwell_q;
        mode_d     = mode_q;
        shadow_d   = shadow_q;
        map_d      = map_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        sweep_d    = sweep_q;

        if (stop) begin
            state_d  = ST_IDLE;
            code_d   = 3'd0;
            dwell_d  = 8'd0;
            shadow_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_DRIVE;
                        code_d   = 3'd0;
                        dwell_d  = 8'd0;
                        mode_d   = mode;
                        shadow_d = 8'd0;
                    end else begin
                        code_d = 3'd0;
                    end
                end
                ST_DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        shadow_d[code_q] = p_in;
                        dwell_d          = 8'd0;
                        if (code_q != 3'd7) begin
                            code_d = code_q + 3'd1;
                        end else begin
                            // The just-captured bit 7 must be included in the published map.
                            state_d    = ST_DONE;
                            code_d     = 3'd0;
                            map_d      = shadow_d;
                            count_d    = popcount8(shadow_d);
                            mismatch_d = (shadow_d != PRIME_REF);
                            if (sweep_q != {SWEEP_W{1'b1}}) begin
                                sweep_d = sweep_q + SWEEP_W'(1);
                            end else begin
                                sweep_d = sweep_q;
                            end
                        end
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    code_d   = 3'd0;
                    dwell_d  = 8'd0;
                    shadow_d = 8'd0;
                    if (mode_q) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    code_d   = 3'd0;
                    dwell_d  = 8'd0;
                    shadow_d = 8'd0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= 3'd0;
            dwell_q    <= 8'd0;
            mode_q     <= 1'b0;
            shadow_q   <= 8'd0;
            map_q      <= 8'd0;
            count_q    <= 4'd0;
            mismatch_q <= 1'b0;
            sweep_q    <= {SWEEP_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            dwell_q    <= dwell_d;
            mode_q     <= mode_d;
            shadow_q   <= shadow_d;
            map_q      <= map_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            sweep_q    <= sweep_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign c           = code_q[2];
    assign b           = code_q[1];
    assign a           = code_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign prime_map   = map_q;
    assign prime_count = count_q;
    assign mismatch    = mismatch_q;
    assign sweep_count = sweep_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Randomized self-checking bench: two sequencers (DWELL=4/SWEEP_W=8 and DWELL=1/SWEEP_W=2)
// share stimulus and are compared every cycle against a timeline-based reference model.
module tb_prime_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] resp;

    logic       c0, b0, a0, busy0, done0, mis0, p0;
    logic [7:0] map0;
    logic [3:0] cnt0;
    logic [7:0] sweep0;
    logic       c1, b1, a1, busy1, done1, mis1, p1;
    logic [7:0] map1;
    logic [3:0] cnt1;
    logic [1:0] sweep1;
    logic [2:0] code0, code1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    assign code0 = {c0, b0, a0};
    assign code1 = {c1, b1, a1};
    assign p0    = resp[code0];
    assign p1    = resp[code1];

    prime_scan_ctrl #(.DWELL(4), .SWEEP_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .c(c0), .b(b0), .a(a0), .p_in(p0), .busy(busy0), .done(done0),
        .prime_map(map0), .prime_count(cnt0), .mismatch(mis0), .sweep_count(sweep0)
    );

    prime_scan_ctrl #(.DWELL(1), .SWEEP_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .c(c1), .b(b1), .a(a1), .p_in(p1), .busy(busy1), .done(done1),
        .prime_map(map1), .prime_count(cnt1), .mismatch(mis1), .sweep_count(sweep1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dw(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int smax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    // Reference model: m_t counts edges since the accepting edge (-1 when idle).
    int         m_t   [2];
    bit         m_mode[2];
    logic [7:0] m_sh  [2];
    logic [7:0] m_map [2];
    int         m_cnt [2];
    bit         m_mis [2];
    int         m_swc [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] <= -1; m_mode[i] <= 1'b0; m_sh[i] <= 8'd0; m_map[i] <= 8'd0;
                m_cnt[i] <= 0; m_mis[i] <= 1'b0; m_swc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int tt;
                int d;
                logic [7:0] s;
                tt = m_t[i];
                d  = dw(i);
                s  = m_sh[i];
                if (stop) begin
                    m_t[i]  <= -1;
                    m_sh[i] <= 8'd0;
                end else if (tt < 0) begin
                    if (start) begin
                        m_t[i] <= 0; m_mode[i] <= mode; m_sh[i] <= 8'd0;
                    end
                end else if (tt == 8 * d) begin
                    m_t[i] <= m_mode[i] ? 0 : -1;
                end else begin
                    tt = tt + 1;
                    if (tt % d == 0) s[tt / d - 1] = resp[tt / d - 1];
                    m_t[i]  <= tt;
                    m_sh[i] <= s;
                    if (tt == 8 * d) begin
                        m_map[i] <= s;
                        m_cnt[i] <= $countones(s);
                        m_mis[i] <= (s != 8'hAC);
                        m_swc[i] <= (m_swc[i] < smax(i)) ? m_swc[i] + 1 : m_swc[i];
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            int a_code[2], a_busy[2], a_done[2], a_map[2], a_cnt[2], a_mis[2], a_swc[2];
            a_code[0] = code0; a_busy[0] = busy0; a_done[0] = done0; a_map[0] = map0;
            a_cnt[0]  = cnt0;  a_mis[0]  = mis0;  a_swc[0]  = sweep0;
            a_code[1] = code1; a_busy[1] = busy1; a_done[1] = done1; a_map[1] = map1;
            a_cnt[1]  = cnt1;  a_mis[1]  = mis1;  a_swc[1]  = sweep1;
            for (int i = 0; i < 2; i++) begin
                int d;
                int e_code;
                d      = dw(i);
                e_code = (m_t[i] >= 0 && m_t[i] < 8 * d) ? m_t[i] / d : 0;
                check($sformatf("code%0d", i),  a_code[i], e_code);
                check($sformatf("busy%0d", i),  a_busy[i], (m_t[i] >= 0) ? 1 : 0);
                check($sformatf("done%0d", i),  a_done[i], (m_t[i] == 8 * d) ? 1 : 0);
                check($sformatf("map%0d", i),   a_map[i],  m_map[i]);
                check($sformatf("count%0d", i), a_cnt[i],  m_cnt[i]);
                check($sformatf("mism%0d", i),  a_mis[i],  m_mis[i]);
                check($sformatf("sweep%0d", i), a_swc[i],  m_swc[i]);
            end
        end
    end

    task automatic pulse_start(input bit m);
        @(posedge clk); #1;
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done0(input int bound, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < bound) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done0) got = 1'b1;
        end
        if (!got) check("done0_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int pulses;
        int last;
        int dcnt;
        bit found;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; resp = 8'hAC;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_map", map0, 0);
        check("rst_sweep", sweep0, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single sweep against the ideal detector.
        pulse_start(1'b0);
        wait_done0(60, n);
        check("done0_edge", n, 32);
        check("map_real", map0, 8'hAC);
        check("count_real", cnt0, 4);
        check("mism_real", mis0, 0);
        check("sweep_real", sweep0, 1);
        check("model_map_pin", m_map[0], 8'hAC);
        @(posedge clk); @(negedge clk);
        check("busy_low_33", busy0, 0);

        // Stuck-at-1 detector output.
        resp = 8'hFF;
        pulse_start(1'b0);
        wait_done0(60, n);
        check("map_stuck", map0, 8'hFF);
        check("count_stuck", cnt0, 8);
        check("mism_stuck", mis0, 1);

        // Continuous mode: DWELL=1 period and SWEEP_W=2 saturation.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        resp = 8'hAC;
        pulse_start(1'b1);
        n = 0; pulses = 0; last = 0;
        while (pulses < 4 && n < 80) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done1) begin
                pulses++;
                if (pulses == 1) check("done1_first", n, 8);
                else check("done1_period", n - last, 9);
                last = n;
                if (pulses == 3) check("sweep1_three", sweep1, 3);
                if (pulses == 4) check("sweep1_sat", sweep1, 3);
            end
        end
        if (pulses < 4) check("done1_timeout", pulses, 4);

        // Stop while the slow instance drives code 5 of its second sweep.
        found = 1'b0;
        for (int k = 0; k < 120 && !found; k++) begin
            @(negedge clk);
            if (sweep0 == 8'd1 && code0 == 3'd5) found = 1'b1;
        end
        check("reach_code5", found, 1);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("stop_busy", busy0, 0);
        check("stop_map", map0, 8'hAC);
        check("stop_sweep", sweep0, 1);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0) dcnt++;
        end
        check("stop_no_done", dcnt, 0);

        // Randomized traffic: start spam, mode toggles, rare stops, changing detector.
        repeat (3000) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            mode  = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0)
                resp = ($urandom_range(0, 1) == 0) ? 8'hAC : 8'($urandom);
        end
        @(posedge clk); #1 start = 1'b0; stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0; resp = 8'hAC;

        // Asynchronous reset mid-sweep at code 3, then a clean sweep.
        pulse_start(1'b0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (code0 == 3'd3) found = 1'b1;
        end
        check("reach_code3", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_code", code0, 0);
        check("arst_busy", busy0, 0);
        check("arst_done", done0, 0);
        check("arst_map", map0, 0);
        check("arst_count", cnt0, 0);
        check("arst_mism", mis0, 0);
        check("arst_sweep", sweep0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_start(1'b0);
        wait_done0(60, n);
        check("post_rst_edge", n, 32);
        check("post_rst_map", map0, 8'hAC);
        check("post_rst_sweep", sweep0, 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_scan_ctrl.md
# prime_scan_ctrl

Sequencer that sits directly upstream of the 3-bit prime detector and also consumes its result. It drives every code 0..7 onto the detector's `c`, `b`, `a` inputs and samples the returned `P`. It builds an 8-bit prime map and a prime count for each sweep and flags any disagreement with the known prime set {2,3,5,7}. It supports single-sweep and continuous modes for board bring-up and self-test.

## Interface
Parameters:
- `DWELL`, default 4: cycles each code is held on the detector inputs before `P` is sampled. Legal range is 1..255.
- `SWEEP_W`, default 8: width of the completed-sweep counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a sweep. Sampled only in IDLE.
- `stop`  in  1  synchronous abort, highest priority after reset.
- `mode`  in  1  0 = single sweep, 1 = continuous. Captured when `start` is accepted.
- `c`, `b`, `a`  out  1 each  code to the detector, code = {c,b,a}.
- `p_in`  in  1  detector result `P` for the code currently driven.
- `busy`  out  1  high in DRIVE and DONE.
- `done`  out  1  one-cycle pulse at the end of each completed sweep.
- `prime_map`  out  8  bit i is the captured `P` for code i.
- `prime_count`  out  4  popcount of `prime_map`, range 0..8.
- `mismatch`  out  1  high when `prime_map` != 8'hAC.
- `sweep_count`  out  SWEEP_W  number of completed sweeps, saturating.

## Operation
- State IDLE:
  - `busy`=0 and code output is 3'b000.
  - `start`=1 with `stop`=0 takes the next state DRIVE, sets code=0 and dwell=0, and latches `mode` into `mode_q`.
- State DRIVE:
  - The code is driven from a register.
  - The dwell counter counts from 0 to DWELL-1.
  - On the edge where dwell==DWELL-1, `p_in` is written into shadow bit [code] and dwell resets to 0.
  - If code<7, code increments. Otherwise the next state is DONE.
  - `p_in` is sampled only on that last dwell cycle, so the detector input has settled for DWELL cycles.
- State DONE, which lasts one cycle:
  - `done`=1 and code output is 3'b000.
  - On entry to DONE, the block updates `prime_map` from the shadow register, `prime_count` from its popcount, and `mismatch`. All three are registered.
  - `sweep_count` increments and holds at all-ones.
  - Next state is DRIVE with code=0 if `mode_q`=1, otherwise IDLE.
- Results are never partial. `prime_map`, `prime_count` and `mismatch` change only on entry to DONE and hold their values between sweeps.
- `stop`=1 in any state:
  - Next state is IDLE.
  - The shadow register is cleared.
  - No `done` pulse is produced.
  - `prime_map`, `prime_count`, `mismatch` and `sweep_count` are unchanged.
- `start` while `busy` is ignored, and `mode` changes while busy have no effect until the next accepted `start`.
- `start` and `stop` asserted together in IDLE: `stop` wins and the block stays in IDLE.
- Reset (`rst_n`=0) at any time returns to IDLE immediately, including mid-sweep. All outputs go to their reset values below.
- Reset values:
  - State is IDLE.
  - `c`=`b`=`a`=0, `busy`=0, `done`=0.
  - `prime_map`=0, `prime_count`=0, `sweep_count`=0.
  - `mismatch`=0. `mismatch` is forced to 0 until the first completed sweep.

## Timing
- Define edge 0 as the edge at which `start` is accepted.
- Code k is driven from edge k·DWELL until edge (k+1)·DWELL.
- `p_in` for code k is captured at edge (k+1)·DWELL.
- `done` and the updated results appear after edge 8·DWELL and last one cycle.
- In continuous mode, code 0 is driven again from edge 8·DWELL+1, so the sweep period is 8·DWELL+1 cycles.
- In single mode, `busy` falls after edge 8·DWELL+1.
- The detector is combinational, so its path from `c`/`b`/`a` to `p_in` must meet one clock period. DWELL=1 is legal under that condition.

## Test plan
- Reset, then DWELL=4, pulse `start` with `mode`=0 while connected to the real detector. Required: `done` pulses once after edge 32, `prime_map`=8'hAC, `prime_count`=4, `mismatch`=0, `sweep_count`=1, and `busy` is low from edge 33.
- Stuck-at fault, forcing `p_in`=1. Required after one sweep: `prime_map`=8'hFF, `prime_count`=8, `mismatch`=1.
- Continuous mode with DWELL=1. Required: `done` pulses every 9 cycles, and `sweep_count` reads 3 after 3 pulses. With SWEEP_W=2, `sweep_count` saturates at 3 on the 4th pulse.
- Assert `stop` while code=5 in the second sweep. Required: no `done`, a return to IDLE next cycle, and the first sweep's results retained.
- Pulse `start` repeatedly mid-sweep and toggle `mode`. Required: sweep timing is unchanged and the latched mode is used.
- Assert `rst_n`=0 mid-sweep at code 3. Required: all outputs go to their reset values asynchronously, the next `start` gives a clean sweep, and `prime_map` reads 8'hAC.
